// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and a duty-conversion helper for the multi-channel PWM
package pwm_pkg;
  localparam int CNT_W_DEF = 16;
  localparam logic [15:0] RST_PERIOD_M1_DEF = 16'hFFFF;
  function automatic int duty_pct_to_counts(input int pct, input int period_m1);
    return ((period_m1 + 1) * pct) / 100;
  endfunction
endpackage

// File: rtl/pwm_cmp_ch.sv
// pwm_cmp_ch: one PWM channel slice, trailing-edge compare plus enable/polarity and output flop
module pwm_cmp_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] per_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic             en_i,
  input  logic             inv_i,
  output logic             pwm_o
);
  logic raw, pwm_d, pwm_q;
  // one extra bit so cnt+duty never wraps; large duties saturate to always-on
  assign raw   = ({1'b0, cnt_i} + {1'b0, duty_i}) > {1'b0, per_i};
  assign pwm_d = (raw & en_i) ^ inv_i;
  assign pwm_o = pwm_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm_q <= 1'b0;
    else      pwm_q <= pwm_d;
  end
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: N-channel trailing-edge PWM with a shared period counter and
// double-buffered duty/period updates applied only at the period wrap
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int               N_CH          = 3,
  parameter int               CNT_W         = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_PERIOD_M1 = CNT_W'(RST_PERIOD_M1_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_W-1:0]      period_m1,
  input  logic [N_CH*CNT_W-1:0] duty_in,
  input  logic                  duty_valid,
  output logic                  duty_ready,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       invert,
  output logic [N_CH-1:0]       pwm_out,
  output logic                  period_start
);
  logic [CNT_W-1:0]      cnt_q, cnt_d, per_q, per_d;
  logic [N_CH*CNT_W-1:0] act_q, act_d, pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d, start_q, start_d, run_q;
  logic                  wrap, accept;
  assign wrap         = cnt_q == per_q;
  assign accept       = duty_valid & ~pend_valid_q;
  assign duty_ready   = ~pend_valid_q;
  assign period_start = start_q;
  assign cnt_d        = wrap ? '0 : cnt_q + CNT_W'(1);
  assign per_d        = wrap ? period_m1 : per_q;
  assign act_d        = (wrap & pend_valid_q) ? pend_q : act_q;
  assign pend_d       = accept ? duty_in : pend_q;
  // an update accepted on the wrap cycle is held for the following wrap
  assign pend_valid_d = accept | (pend_valid_q & ~wrap);
  // the reset-state cnt==0 is not a real period start, so it is masked until the first clock
  assign start_d      = run_q & (cnt_q == '0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      per_q        <= RST_PERIOD_M1;
      act_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      start_q      <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      per_q        <= per_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      start_q      <= start_d;
      run_q        <= 1'b1;
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_cmp_ch #(.CNT_W(CNT_W)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .cnt_i  (cnt_q),
      .per_i  (per_q),
      .duty_i (act_q[i*CNT_W +: CNT_W]),
      .en_i   (ch_en[i]),
      .inv_i  (invert[i]),
      .pwm_o  (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed checks of pwm_multi with CNT_W=8, three channels
module tb_pwm_multi;
  localparam int N_CH = 3;
  localparam int CNT_W = 8;
  logic                  clk = 1'b0;
  logic                  rst;
  logic [CNT_W-1:0]      period_m1;
  logic [N_CH*CNT_W-1:0] duty_in;
  logic                  duty_valid;
  logic                  duty_ready;
  logic [N_CH-1:0]       ch_en;
  logic [N_CH-1:0]       invert;
  logic [N_CH-1:0]       pwm_out;
  logic                  period_start;
  int n_cmp = 0;
  int n_err = 0;
  int n;
  pwm_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .RST_PERIOD_M1(8'hFF)) dut (
    .clk          (clk),
    .rst          (rst),
    .period_m1    (period_m1),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .ch_en        (ch_en),
    .invert       (invert),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );
  always #5 clk = ~clk;
  function automatic logic [23:0] pack(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    return {a2, a1, a0};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_start();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (period_start !== 1'b1 && k < 400);
    chk("wait_start", 32'(period_start), 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b0; period_m1 = 8'd9; duty_in = pack(3, 3, 3); duty_valid = 1'b1;
    ch_en = 3'b111; invert = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_ready", 32'(duty_ready), 1);
    chk("rst_start", 32'(period_start), 0);
    rst = 1'b1; duty_valid = 1'b0; duty_in = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 400);
    chk("first_start_latency", 32'(n), 257);
    duty_in = pack(3, 0, 10); duty_valid = 1'b1;
    @(negedge clk);
    chk("ready_drop", 32'(duty_ready), 0);
    duty_valid = 1'b0;
    wait_start();
    for (int j = 0; j < 10; j++) begin
      chk("basic_pwm", 32'(pwm_out), 32'({1'b1, 1'b0, j >= 7}));
      chk("basic_start", 32'(period_start), 32'(j == 0));
      chk("basic_ready", 32'(duty_ready), 1);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    duty_in = pack(8, 255, 10); duty_valid = 1'b1;
    @(negedge clk);
    duty_valid = 1'b0;
    for (int j = 5; j < 10; j++) begin
      chk("hold_pwm", 32'(pwm_out), 32'({1'b1, 1'b0, j >= 7}));
      chk("hold_ready", 32'(duty_ready), 32'(j == 9));
      @(negedge clk);
    end
    for (int j = 0; j < 10; j++) begin
      chk("new_duty_pwm", 32'(pwm_out), 32'({1'b1, 1'b1, j >= 2}));
      chk("wrap_offer_ready", 32'(duty_ready), 32'(j < 9));
      if (j == 8) begin
        duty_in = pack(5, 255, 10); duty_valid = 1'b1;
      end
      if (j == 9) duty_valid = 1'b0;
      @(negedge clk);
    end
    for (int j = 0; j < 10; j++) begin
      chk("wrap_offer_hold_pwm", 32'(pwm_out), 32'({1'b1, 1'b1, j >= 2}));
      chk("wrap_offer_hold_ready", 32'(duty_ready), 32'(j == 9));
      @(negedge clk);
    end
    for (int j = 0; j < 10; j++) begin
      chk("late_duty_pwm", 32'(pwm_out), 32'({1'b1, 1'b1, j >= 5}));
      chk("late_duty_start", 32'(period_start), 32'(j == 0));
      if (j == 5) period_m1 = 8'd4;
      @(negedge clk);
    end
    for (int j = 0; j < 5; j++) begin
      chk("short_pwm", 32'(pwm_out), 32'(3'b111));
      chk("short_start", 32'(period_start), 32'(j == 0));
      @(negedge clk);
    end
    chk("short_period_len", 32'(period_start), 1);
    period_m1 = 8'd9; duty_in = pack(3, 3, 0); duty_valid = 1'b1;
    ch_en = 3'b101; invert = 3'b011;
    @(negedge clk);
    duty_valid = 1'b0;
    wait_start();
    for (int j = 0; j < 10; j++) begin
      chk("en_inv_pwm", 32'(pwm_out), 32'({1'b0, 1'b1, j < 7}));
      chk("en_inv_start", 32'(period_start), 32'(j == 0));
      @(negedge clk);
    end
    period_m1 = 8'd0; duty_in = pack(1, 0, 1); duty_valid = 1'b1;
    ch_en = 3'b111; invert = 3'b000;
    @(negedge clk);
    duty_valid = 1'b0;
    wait_start();
    for (int j = 0; j < 5; j++) begin
      chk("p0_pwm", 32'(pwm_out), 32'(3'b101));
      chk("p0_start", 32'(period_start), 1);
      chk("p0_ready", 32'(duty_ready), 1);
      @(negedge clk);
    end
    period_m1 = 8'd9;
    repeat (3) @(negedge clk);
    duty_in = pack(10, 10, 10); duty_valid = 1'b1;
    @(negedge clk);
    chk("mid_pend_ready", 32'(duty_ready), 0);
    duty_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_pwm", 32'(pwm_out), 0);
    chk("async_rst_ready", 32'(duty_ready), 1);
    chk("async_rst_start", 32'(period_start), 0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 400);
    chk("rerun_start_latency", 32'(n), 257);
    chk("rerun_pend_dropped", 32'(pwm_out), 0);
    chk("rerun_ready", 32'(duty_ready), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
